// File: rtl/wr0_addr_ctr.sv
// -----------------------------------------------------------------------------
// wr0_addr_ctr
//
// Write-address sequencer for video frame buffer 0. A rising edge on vsync
// starts a frame; the block then issues BURST_PER_FRAME burst requests to a
// DDR write engine. Each request waits for the write FIFO to be ready and is
// retired by a rising edge on wr_ddr_done. Consecutive bursts are WR_STRIDE
// words apart. At the end of every frame a frame_done pulse is produced and
// a 5-bit frame counter advances.
//
// Optional feature (macro WR0_PINGPONG_EN): when defined, the frame base
// alternates between START_ADDR and START_ADDR + FRAME_STRIDE on every
// completed frame. When undefined, every frame starts at START_ADDR.
//
// Ports
//   clk           in   single clock
//   rst           in   synchronous active-high reset
//   vsync         in   frame start (rising edge, asynchronous to clk)
//   fifo_rdy      in   write FIFO holds at least WR_NUM words
//   wr_ddr_done   in   DDR engine completion level (rising edge ends a burst)
//   wr_ddr_valid  out  one-cycle burst request
//   wr_ddr_addr   out  byte address of the current burst (word address * 4)
//   wr_ddr_num    out  burst length, constant WR_NUM
//   wr_image_cnt  out  completed frames, modulo 32
//   frame_done    out  one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module wr0_addr_ctr #(
  parameter logic [31:0] START_ADDR      = 32'h0078_0000,
  parameter logic [31:0] WR_STRIDE       = 32'h0000_0080,
  parameter int          BURST_PER_FRAME = 512,
  parameter logic [31:0] WR_NUM          = 32'd512,
  parameter logic [31:0] FRAME_STRIDE    = 32'h0010_0000,
  parameter int          ADDR_WIDTH      = 30,
  parameter int          WR_NUM_WIDTH    = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync,
  input  logic                    fifo_rdy,
  input  logic                    wr_ddr_done,
  output logic                    wr_ddr_valid,
  output logic [ADDR_WIDTH-1:0]   wr_ddr_addr,
  output logic [WR_NUM_WIDTH-1:0] wr_ddr_num,
  output logic [4:0]              wr_image_cnt,
  output logic                    frame_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] START_W    = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_W   = ADDR_WIDTH'(WR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] FRAME_W    = ADDR_WIDTH'(FRAME_STRIDE);
  localparam logic [15:0]           LAST_BURST = 16'(BURST_PER_FRAME - 1);

  state_t                  state;
  logic [15:0]             burst_cnt;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [ADDR_WIDTH-1:0]   frame_base;

  // Synchronizer and edge-detect chains: p0/p1 resynchronise, p2 holds the
  // previous synchronised level, rise_p3 is the registered edge pulse.
  logic vsync_p0, vsync_p1, vsync_p2, vsync_rise_p3;
  logic done_p0,  done_p1,  done_p2,  done_rise_p3;

  // --- stage p0..p3: input synchronisation and rising-edge detection ---
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_p0      <= 1'b0;
      vsync_p1      <= 1'b0;
      vsync_p2      <= 1'b0;
      vsync_rise_p3 <= 1'b0;
      done_p0       <= 1'b0;
      done_p1       <= 1'b0;
      done_p2       <= 1'b0;
      done_rise_p3  <= 1'b0;
    end else begin
      vsync_p0      <= vsync;
      vsync_p1      <= vsync_p0;
      vsync_p2      <= vsync_p1;
      vsync_rise_p3 <= vsync_p1 & ~vsync_p2;
      done_p0       <= wr_ddr_done;
      done_p1       <= done_p0;
      done_p2       <= done_p1;
      done_rise_p3  <= done_p1 & ~done_p2;
    end
  end

`ifdef WR0_PINGPONG_EN
  logic pp_sel;
  assign frame_base = pp_sel ? (START_W + FRAME_W) : START_W;
`else
  logic unused_frame_stride;
  assign frame_base          = START_W;
  assign unused_frame_stride = ^FRAME_W;
`endif

  // --- burst sequencing FSM: consumes the registered edge pulses ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ddr_valid <= 1'b0;
      frame_done   <= 1'b0;
      wr_image_cnt <= 5'd0;
      burst_cnt    <= 16'd0;
      word_addr    <= START_W;
`ifdef WR0_PINGPONG_EN
      pp_sel       <= 1'b0;
`endif
    end else begin
      wr_ddr_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          burst_cnt <= 16'd0;
          word_addr <= frame_base;
          if (vsync_rise_p3) state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (fifo_rdy) begin
            wr_ddr_valid <= 1'b1;
            state        <= BURST;
          end
        end
        BURST: begin
          // Address only moves once the engine has finished with it, so
          // wr_ddr_addr is stable for the whole burst.
          if (done_rise_p3) begin
            burst_cnt <= burst_cnt + 16'd1;
            word_addr <= word_addr + STRIDE_W;
            state     <= (burst_cnt == LAST_BURST) ? FRAME_END : WAIT_DATA;
          end
        end
        FRAME_END: begin
          frame_done   <= 1'b1;
          wr_image_cnt <= wr_image_cnt + 5'd1;
`ifdef WR0_PINGPONG_EN
          pp_sel       <= ~pp_sel;
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte address; the shift drops the top two word-address bits.
  assign wr_ddr_addr = word_addr << 2;
  assign wr_ddr_num  = WR_NUM_WIDTH'(WR_NUM);

endmodule

// File: tb/tb_wr0_addr_ctr.sv
module tb_wr0_addr_ctr;

  localparam logic [31:0] START  = 32'h0078_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0080;
  localparam logic [31:0] FSTR   = 32'h0010_0000;
  localparam logic [31:0] WRN    = 32'd512;
  localparam int          BPF    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        fifo_rdy = 1'b0;
  logic        wr_ddr_done = 1'b0;
  logic        wr_ddr_valid;
  logic [29:0] wr_ddr_addr;
  logic [27:0] wr_ddr_num;
  logic [4:0]  wr_image_cnt;
  logic        frame_done;

  always #5 clk = ~clk;

  wr0_addr_ctr #(
    .START_ADDR(START), .WR_STRIDE(STRIDE), .BURST_PER_FRAME(BPF),
    .WR_NUM(WRN), .FRAME_STRIDE(FSTR), .ADDR_WIDTH(30), .WR_NUM_WIDTH(28)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .fifo_rdy(fifo_rdy),
    .wr_ddr_done(wr_ddr_done), .wr_ddr_valid(wr_ddr_valid),
    .wr_ddr_addr(wr_ddr_addr), .wr_ddr_num(wr_ddr_num),
    .wr_image_cnt(wr_image_cnt), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;

  // Observation of DUT outputs on the falling edge.
  logic [29:0] vq[$];
  int          fd_count = 0;
  int          b2b = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (wr_ddr_valid) vq.push_back(wr_ddr_addr);
    if (wr_ddr_valid && prev_valid) b2b++;
    prev_valid = wr_ddr_valid;
    if (frame_done) fd_count++;
  end

  // Reference model: frames completed since reset and ping-pong selector.
  int frames = 0;
  bit pp = 1'b0;

  function automatic logic [29:0] exp_addr(input int k);
    longint base;
    base = longint'(START);
`ifdef WR0_PINGPONG_EN
    if (pp) base = base + longint'(FSTR);
`endif
    return 30'((base + longint'(k) * longint'(STRIDE)) * 4);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; vsync = 1'b0; wr_ddr_done = 1'b0; fifo_rdy = 1'b0;
    tick(3);
    rst = 1'b0;
    frames = 0;
    pp = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(1);
  endtask

  task automatic serve_burst(input int k);
    int t;
    t = 0;
    while (vq.size() <= k && t < 200) begin
      tick(1);
      t++;
    end
    tests++;
    if (vq.size() <= k) begin
      $display("FAIL burst%0d_valid: got no valid pulse, required one", k);
      fails++;
      return;
    end
    tests++;
    if (vq[k] !== exp_addr(k)) begin
      $display("FAIL burst%0d_addr: got %h, required %h", k, vq[k], exp_addr(k));
      fails++;
    end
    tick($urandom_range(0, 4));
    wr_ddr_done = 1'b1;
    tests++;
    if (wr_ddr_addr !== vq[k]) begin
      $display("FAIL burst%0d_addr_stable: got %h, required %h", k, wr_ddr_addr, vq[k]);
      fails++;
    end
    tick(2);
    wr_ddr_done = 1'b0;
    tick(1);
  endtask

  task automatic complete_frame(input int fd0);
    int t;
    for (int k = 0; k < BPF; k++) serve_burst(k);
    t = 0;
    while (fd_count == fd0 && t < 200) begin
      tick(1);
      t++;
    end
    tick(3);
    frames++;
    pp = ~pp;
    tests++;
    if (fd_count !== fd0 + 1) begin
      $display("FAIL frame_done_count: got %0d, required %0d", fd_count - fd0, 1);
      fails++;
    end
    tests++;
    if (wr_image_cnt !== 5'(frames % 32)) begin
      $display("FAIL image_cnt: got %0d, required %0d", wr_image_cnt, frames % 32);
      fails++;
    end
    tests++;
    if (vq.size() !== BPF) begin
      $display("FAIL burst_count: got %0d, required %0d", vq.size(), BPF);
      fails++;
    end
  endtask

  task automatic run_frame();
    int fd0;
    fd0 = fd_count;
    vq.delete();
    fifo_rdy = 1'b1;
    pulse_vsync();
    complete_frame(fd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b0; wr_ddr_done = 1'b0; fifo_rdy = 1'b0;
    tick(3);
    tests++;
    if (wr_ddr_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b, required 0", wr_ddr_valid); fails++;
    end
    tests++;
    if (frame_done !== 1'b0) begin
      $display("FAIL reset_frame_done: got %b, required 0", frame_done); fails++;
    end
    tests++;
    if (wr_image_cnt !== 5'd0) begin
      $display("FAIL reset_image_cnt: got %0d, required 0", wr_image_cnt); fails++;
    end
    tests++;
    if (wr_ddr_addr !== 30'h01E0_0000) begin
      $display("FAIL reset_addr: got %h, required %h", wr_ddr_addr, 30'h01E0_0000); fails++;
    end
    tests++;
    if (wr_ddr_num !== 28'd512) begin
      $display("FAIL wr_ddr_num: got %0d, required 512", wr_ddr_num); fails++;
    end
    rst = 1'b0;
    frames = 0;
    pp = 1'b0;
    vq.delete();
    fifo_rdy = 1'b1;
    tick(20);
    tests++;
    if (vq.size() !== 0) begin
      $display("FAIL no_start_without_vsync: got %0d valid pulses, required 0", vq.size()); fails++;
    end
  endtask

  task automatic test_basic_frame();
    run_frame();
    tests++;
    if (wr_image_cnt !== 5'd1) begin
      $display("FAIL basic_image_cnt: got %0d, required 1", wr_image_cnt); fails++;
    end
  endtask

  task automatic test_fifo_stall();
    int fd0;
    fd0 = fd_count;
    vq.delete();
    fifo_rdy = 1'b0;
    pulse_vsync();
    tick(100);
    tests++;
    if (vq.size() !== 0) begin
      $display("FAIL stall_no_valid: got %0d valid pulses, required 0", vq.size()); fails++;
    end
    fifo_rdy = 1'b1;
    tick(1);
    tests++;
    if (wr_ddr_valid !== 1'b1) begin
      $display("FAIL stall_valid_latency: got %b, required 1", wr_ddr_valid); fails++;
    end
    complete_frame(fd0);
  endtask

  task automatic test_image_cnt_wrap();
    apply_reset();
    for (int f = 0; f < 32; f++) run_frame();
    tests++;
    if (wr_image_cnt !== 5'd0) begin
      $display("FAIL image_cnt_wrap: got %0d, required 0", wr_image_cnt); fails++;
    end
  endtask

  task automatic test_spurious();
    int fd0;
    logic [29:0] a0;
    fd0 = fd_count;
    vq.delete();
    fifo_rdy = 1'b0;
    pulse_vsync();
    tick(5);
    a0 = exp_addr(0);
    pulse_vsync();
    wr_ddr_done = 1'b1;
    tick(2);
    wr_ddr_done = 1'b0;
    tick(10);
    tests++;
    if (wr_ddr_addr !== a0) begin
      $display("FAIL spurious_addr: got %h, required %h", wr_ddr_addr, a0); fails++;
    end
    tests++;
    if (vq.size() !== 0 || fd_count !== fd0) begin
      $display("FAIL spurious_activity: got %0d valids %0d frames, required 0 0",
               vq.size(), fd_count - fd0);
      fails++;
    end
    fifo_rdy = 1'b1;
    complete_frame(fd0);
    tick(20);
    tests++;
    if (vq.size() !== BPF) begin
      $display("FAIL spurious_extra_burst: got %0d bursts, required %0d", vq.size(), BPF); fails++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int fd0;
    int t;
    fd0 = fd_count;
    vq.delete();
    fifo_rdy = 1'b1;
    pulse_vsync();
    serve_burst(0);
    t = 0;
    while (vq.size() < 2 && t < 200) begin
      tick(1);
      t++;
    end
    tests++;
    if (vq.size() < 2) begin
      $display("FAIL midrst_second_valid: got %0d valids, required 2", vq.size()); fails++;
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    frames = 0;
    pp = 1'b0;
    wr_ddr_done = 1'b1;
    tick(3);
    wr_ddr_done = 1'b0;
    tick(30);
    tests++;
    if (vq.size() !== 2) begin
      $display("FAIL midrst_no_valid: got %0d valids, required 2", vq.size()); fails++;
    end
    tests++;
    if (wr_image_cnt !== 5'd0) begin
      $display("FAIL midrst_image_cnt: got %0d, required 0", wr_image_cnt); fails++;
    end
    tests++;
    if (wr_ddr_addr !== 30'h01E0_0000 || fd_count !== fd0) begin
      $display("FAIL midrst_state: got addr %h frames %0d, required addr %h frames 0",
               wr_ddr_addr, fd_count - fd0, 30'h01E0_0000);
      fails++;
    end
    run_frame();
    tests++;
    if (vq[0] !== 30'h01E0_0000) begin
      $display("FAIL midrst_restart_addr: got %h, required %h", vq[0], 30'h01E0_0000); fails++;
    end
  endtask

  task automatic test_pingpong();
    apply_reset();
    run_frame();
    tests++;
    if (vq[0] !== 30'h01E0_0000) begin
      $display("FAIL frame0_base: got %h, required %h", vq[0], 30'h01E0_0000); fails++;
    end
    run_frame();
`ifdef WR0_PINGPONG_EN
    tests++;
    if (vq[0] !== 30'h0220_0000) begin
      $display("FAIL frame1_base: got %h, required %h", vq[0], 30'h0220_0000); fails++;
    end
`else
    tests++;
    if (vq[0] !== 30'h01E0_0000) begin
      $display("FAIL frame1_base: got %h, required %h", vq[0], 30'h01E0_0000); fails++;
    end
`endif
  endtask

  task automatic test_back_to_back();
    tests++;
    if (b2b !== 0) begin
      $display("FAIL back_to_back_valid: got %0d occurrences, required 0", b2b); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fifo_stall();
    test_spurious();
    test_reset_mid_burst();
    test_pingpong();
    test_image_cnt_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/wr0_addr_ctr.md
WR0_ADDR_CTR -- requirements
Module: wr0_addr_ctr

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h0078_0000: word base address of frame buffer 0.
REQ-002 SHALL have parameter WR_STRIDE, default 32'h0000_0080: word address increment between consecutive bursts.
REQ-003 SHALL have parameter BURST_PER_FRAME, default 512: bursts per frame (2..65535).
REQ-004 SHALL have parameter WR_NUM, default 32'd512: burst length constant driven on wr_ddr_num.
REQ-005 SHALL have parameter FRAME_STRIDE, default 32'h0010_0000: word offset of frame buffer 1 (used only with WR0_PINGPONG_EN).
REQ-006 SHALL have parameters ADDR_WIDTH, default 30, and WR_NUM_WIDTH, default 28.
REQ-007 SHALL have port clk, input, 1: single clock; one clock and synchronous active-high reset.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port vsync, input, 1: frame-start from video input; rising edge starts a frame.
REQ-010 SHALL have port fifo_rdy, input, 1: write FIFO holds at least WR_NUM words.
REQ-011 SHALL have port wr_ddr_done, input, 1: DDR write engine completion level; rising edge ends the burst.
REQ-012 SHALL have port wr_ddr_valid, output, 1: one-cycle burst request pulse.
REQ-013 SHALL have port wr_ddr_addr, output, ADDR_WIDTH: byte address, equal to the internal word address times 4.
REQ-014 SHALL have port wr_ddr_num, output, WR_NUM_WIDTH: constant WR_NUM.
REQ-015 SHALL have port wr_image_cnt, output, 5: count of completed frames, modulo 32.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse per completed frame.

Function
REQ-017 SHALL register vsync and wr_ddr_done through two flops each, then detect rising edges (old = 0, new = 1); the edge pulses are registered, giving 3 cycles of input-to-pulse latency.
REQ-018 SHALL implement a state machine with states IDLE, WAIT_DATA, BURST and FRAME_END.
REQ-019 IDLE: the block SHALL load the burst counter with 0 and the word address with the frame base; on a vsync rise it SHALL go to WAIT_DATA.
REQ-020 WAIT_DATA: when fifo_rdy = 1, the block SHALL pulse wr_ddr_valid for exactly 1 cycle and go to BURST; otherwise it SHALL hold.
REQ-021 BURST: on a done-rise pulse, the block SHALL increment the burst counter and add WR_STRIDE to the word address; it SHALL then go to FRAME_END if the counter was BURST_PER_FRAME-1, else to WAIT_DATA.
REQ-022 FRAME_END: the block SHALL pulse frame_done for 1 cycle, increment wr_image_cnt (31 wraps to 0) in the same cycle, and return to IDLE.
REQ-023 wr_ddr_addr SHALL remain stable from the valid pulse until the done-rise pulse is consumed.
REQ-024 Word address arithmetic SHALL be ADDR_WIDTH bits and wrap silently; the multiply by 4 SHALL be truncated to ADDR_WIDTH.
REQ-025 A vsync rise outside IDLE SHALL be ignored, and the current frame SHALL run to completion.
REQ-026 A done-rise outside BURST SHALL be ignored, with no counter or address change.
REQ-027 If fifo_rdy stays high, the gap between consecutive valid pulses SHALL be the done latency plus 4 cycles, with no back-to-back valid.
REQ-028 A vsync rise in the same cycle FRAME_END returns to IDLE SHALL be lost; only a rise detected while in IDLE starts a frame.

Reset
REQ-029 On rst = 1 at a clock edge, the block SHALL load state IDLE; wr_ddr_valid = 0, frame_done = 0, wr_image_cnt = 0, burst counter = 0, word address = START_ADDR, and all synchronizer/edge flops = 0.
REQ-030 Reset asserted mid-burst SHALL abandon the frame with no further valid pulses; a late wr_ddr_done after reset SHALL be ignored.
REQ-031 After reset release, the first frame SHALL start only on a new vsync rise.

Configuration
REQ-032 With macro WR0_PINGPONG_EN defined, the frame base SHALL alternate START_ADDR, START_ADDR+FRAME_STRIDE, START_ADDR, and so on, toggling at FRAME_END; the toggle SHALL reset to 0 (START_ADDR).
REQ-033 With WR0_PINGPONG_EN undefined, the frame base SHALL always be START_ADDR, and FRAME_STRIDE SHALL be unused.

Verification
REQ-034 Reset, then vsync rise with fifo_rdy = 1 and BURST_PER_FRAME = 4 -> 4 valid pulses at byte addresses 0x01E00000, 0x01E00200, 0x01E00400, 0x01E00600; frame_done pulses once; wr_image_cnt = 1.
REQ-035 fifo_rdy held 0 for 100 cycles in WAIT_DATA -> no valid pulse; valid follows 1 cycle after fifo_rdy rises.
REQ-036 Run 32 frames -> wr_image_cnt steps 0..31, then 0; the 31 -> 0 transition occurs at frame_done of frame 32.
REQ-037 Extra vsync rise and spurious wr_ddr_done pulse during WAIT_DATA -> no address or counter change; the frame still completes with exactly 4 bursts.
REQ-038 rst pulsed during the 2nd BURST, then wr_ddr_done rises -> no valid pulse; wr_image_cnt = 0; the next vsync restarts at 0x01E00000.
REQ-039 With WR0_PINGPONG_EN and FRAME_STRIDE = 0x100000, two frames -> the first bursts are at 0x01E00000 and 0x02200000 respectively.
